// File: rtl/serial_descrambler.sv
// Self-synchronising serial descrambler for G(x) = x^58 + x^39 + 1.
// Lock is acquired by counting received bits. During idle, bit errors are counted and runs of them cause loss of lock.
module serial_descrambler #(
  parameter int LOCK_LEN = 58,
  parameter int ERR_W    = 16,
  parameter int ERR_RUN  = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             enable,
  input  logic             Bit_In,
  input  logic             resync,
  input  logic             expect_zero,
  output logic             Bit_Out,
  output logic             Bit_Valid,
  output logic             locked,
  output logic [ERR_W-1:0] err_count,
  output logic             err_sat
);

  typedef enum logic {FILL, LOCKED} state_t;

  state_t           r_state, w_state_nx;
  logic [57:0]      r_s;
  logic [7:0]       r_fill, w_fill_nx;
  logic [7:0]       r_run, w_run_nx;
  logic [ERR_W-1:0] w_err_nx;
  logic             w_d;
  logic             w_err_bit;

  assign locked  = (r_state == LOCKED);
  assign err_sat = &err_count;

  always_comb begin
    w_d        = Bit_In ^ r_s[57] ^ r_s[38];
    w_err_bit  = enable && expect_zero && w_d && (r_state == LOCKED) && !resync;
    w_state_nx = r_state;
    w_fill_nx  = r_fill;
    w_run_nx   = r_run;
    w_err_nx   = err_count;
    // resync wins over a coincident loss of lock, so err_count is cleared
    if (resync) begin
      w_state_nx = FILL;
      w_fill_nx  = '0;
      w_run_nx   = '0;
      w_err_nx   = '0;
    end else if (enable) begin
      unique case (r_state)
        FILL: begin
          if (r_fill + 8'd1 == 8'(LOCK_LEN)) begin
            w_state_nx = LOCKED;
            w_fill_nx  = '0;
          end else begin
            w_fill_nx = r_fill + 8'd1;
          end
        end
        LOCKED: begin
          if (w_err_bit) begin
            if (!err_sat) w_err_nx = err_count + ERR_W'(1);
            if (r_run + 8'd1 == 8'(ERR_RUN)) begin
              w_state_nx = FILL;
              w_fill_nx  = '0;
              w_run_nx   = '0;
            end else begin
              w_run_nx = r_run + 8'd1;
            end
          end else begin
            w_run_nx = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state   <= FILL;
      r_s       <= '0;
      r_fill    <= '0;
      r_run     <= '0;
      err_count <= '0;
      Bit_Out   <= 1'b0;
      Bit_Valid <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_fill    <= w_fill_nx;
      r_run     <= w_run_nx;
      err_count <= w_err_nx;
      Bit_Valid <= enable;
      if (enable) begin
        // history holds received line bits, which keeps the descrambler self-synchronising
        r_s     <= {r_s[56:0], Bit_In};
        Bit_Out <= w_d;
      end
    end
  end

endmodule

// File: tb/tb_serial_descrambler.sv
// Scoreboard bench for serial_descrambler: a reference scrambler produces the line bits.
// A negedge monitor pops expected output bits and state probes and compares them.
module tb_serial_descrambler;

  logic        CLK = 1'b0;
  logic        reset, enable, Bit_In, resync, expect_zero;
  logic        Bit_Out, Bit_Valid, locked, err_sat;
  logic [15:0] err_count;
  logic        Bit_Out2, Bit_Valid2, locked2, err_sat2;
  logic [3:0]  err_count2;

  always #5 CLK = ~CLK;

  serial_descrambler dut (
    .CLK(CLK), .reset(reset), .enable(enable), .Bit_In(Bit_In), .resync(resync),
    .expect_zero(expect_zero), .Bit_Out(Bit_Out), .Bit_Valid(Bit_Valid),
    .locked(locked), .err_count(err_count), .err_sat(err_sat)
  );

  serial_descrambler #(.LOCK_LEN(58), .ERR_W(4), .ERR_RUN(255)) dut2 (
    .CLK(CLK), .reset(reset), .enable(enable), .Bit_In(Bit_In), .resync(resync),
    .expect_zero(expect_zero), .Bit_Out(Bit_Out2), .Bit_Valid(Bit_Valid2),
    .locked(locked2), .err_count(err_count2), .err_sat(err_sat2)
  );

  typedef enum int {K_BV, K_BO, K_LK, K_ERR, K_SAT, K_BV2, K_BO2, K_LK2, K_ERR2, K_SAT2, K_DRAIN} kind_t;
  typedef struct {
    string nm;
    kind_t k;
    int    e;
  } probe_t;

  logic        expq[$];
  probe_t      prq[$];
  int          total = 0;
  int          bad   = 0;
  logic [57:0] sc;
  bit          ep[0:4095];
  int          bidx;

  function automatic void check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  always @(negedge CLK) begin
    if (Bit_Valid === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL bit_out: got unexpected valid bit %0d expected none (t=%0t)", Bit_Out, $time);
      end else begin
        logic e;
        e = expq.pop_front();
        check("bit_out", int'(Bit_Out), int'(e));
      end
    end
    while (prq.size() > 0) begin
      probe_t p;
      int     act;
      p = prq.pop_front();
      case (p.k)
        K_BV:    act = int'(Bit_Valid);
        K_BO:    act = int'(Bit_Out);
        K_LK:    act = int'(locked);
        K_ERR:   act = int'(err_count);
        K_SAT:   act = int'(err_sat);
        K_BV2:   act = int'(Bit_Valid2);
        K_BO2:   act = int'(Bit_Out2);
        K_LK2:   act = int'(locked2);
        K_ERR2:  act = int'(err_count2);
        K_SAT2:  act = int'(err_sat2);
        default: act = expq.size();
      endcase
      check(p.nm, act, p.e);
    end
  end

  task automatic pr(input string nm, input kind_t k, input int e);
    probe_t p;
    p.nm = nm;
    p.k  = k;
    p.e  = e;
    prq.push_back(p);
  endtask

  task automatic clr_model();
    sc   = '0;
    bidx = 0;
    foreach (ep[i]) ep[i] = 1'b0;
  endtask

  // One cycle of stimulus; a flip corrupts the line bit and hence outputs at +0, +39, +58.
  task automatic bitx(input logic en, input logic pay, input logic flp, input logic rs, input logic ez);
    logic o;
    enable      = en;
    resync      = rs;
    expect_zero = ez;
    Bit_In      = 1'b0;
    if (en) begin
      if (flp) begin
        ep[bidx]    = !ep[bidx];
        ep[bidx+39] = !ep[bidx+39];
        ep[bidx+58] = !ep[bidx+58];
      end
      o  = pay ^ sc[57] ^ sc[38];
      sc = {sc[56:0], o};
      Bit_In = o ^ flp;
      expq.push_back(pay ^ ep[bidx]);
      bidx++;
    end
    @(posedge CLK);
    #1;
    enable = 1'b0;
    resync = 1'b0;
  endtask

  task automatic rawbit(input logic bin, input logic ex);
    enable      = 1'b1;
    Bit_In      = bin;
    resync      = 1'b0;
    expect_zero = 1'b0;
    expq.push_back(ex);
    @(posedge CLK);
    #1;
    enable = 1'b0;
  endtask

  task automatic do_reset(input logic en_during);
    reset       = 1'b1;
    enable      = en_during;
    Bit_In      = 1'b1;
    resync      = 1'b0;
    expect_zero = 1'b0;
    @(posedge CLK);
    #1;
    reset  = 1'b0;
    enable = 1'b0;
    Bit_In = 1'b0;
    clr_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    int cnt;
    reset = 1'b1; enable = 1'b0; Bit_In = 1'b0; resync = 1'b0; expect_zero = 1'b0;
    clr_model();

    do_reset(1'b0);
    pr("rst_bv", K_BV, 0);   pr("rst_bo", K_BO, 0);   pr("rst_lk", K_LK, 0);
    pr("rst_err", K_ERR, 0); pr("rst_sat", K_SAT, 0); pr("rst_bv2", K_BV2, 0);
    pr("rst_lk2", K_LK2, 0); pr("rst_err2", K_ERR2, 0); pr("rst_sat2", K_SAT2, 0);

    // impulse response: line ones at 0, 39, 58 give a single output one at 0
    for (int i = 0; i < 78; i++) begin
      rawbit((i == 0) || (i == 39) || (i == 58), i == 0);
      if (i == 0) pr("t1_bv_latency", K_BV, 1);
    end
    bitx(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pr("t1_idle_bv", K_BV, 0);

    // gapped fill: lock appears only after the 58th enabled bit
    do_reset(1'b0);
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 58; c++) begin
      if (c % 3 == 2) begin
        bitx(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pr("t2_gap_bv", K_BV, 0);
        pr("t2_gap_lk", K_LK, 0);
      end else begin
        bitx(1'b1, (cnt % 5) == 1, 1'b0, 1'b0, 1'b0);
        cnt++;
        if (cnt == 57) pr("t2_lk_57", K_LK, 0);
        if (cnt == 58) pr("t2_lk_58", K_LK, 1);
      end
    end

    // five isolated line flips while locked on idle
    for (int i = 0; i < 560; i++) begin
      bitx(1'b1, 1'b0, ((i % 100) == 10) && (i < 500), 1'b0, 1'b1);
      if (i == 200) begin
        pr("t3_err_mid", K_ERR, 6);
        pr("t3_lk_mid", K_LK, 1);
      end
    end
    pr("t3_err", K_ERR, 15); pr("t3_lk", K_LK, 1); pr("t3_sat", K_SAT, 0);

    // reset mid-stream with enable high, scrambler reset in the same cycle
    bitx(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset(1'b1);
    pr("t6_bv", K_BV, 0); pr("t6_bo", K_BO, 0); pr("t6_lk", K_LK, 0); pr("t6_err", K_ERR, 0);
    bitx(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    pr("t6_first_bo", K_BO, 1);
    bitx(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bitx(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // complete the fill, then a run of eight errored bits drops lock
    for (int i = 0; i < 55; i++) bitx(1'b1, i[0], 1'b0, 1'b0, 1'b0);
    pr("t4_lk_init", K_LK, 1);
    for (int i = 0; i < 5; i++) bitx(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      bitx(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      if (k == 6) pr("t4_lk_run7", K_LK, 1);
      if (k == 7) begin
        pr("t4_lk_run8", K_LK, 0);
        pr("t4_err_run8", K_ERR, 8);
      end
    end
    for (int n = 1; n <= 60; n++) begin
      bitx(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (n == 57) pr("t4_relock_57", K_LK, 0);
      if (n == 58) begin
        pr("t4_relock_58", K_LK, 1);
        pr("t4_err_relock", K_ERR, 8);
      end
    end
    pr("t4_err_end", K_ERR, 8);

    // narrow counter saturation, then resync with enable
    do_reset(1'b0);
    for (int i = 0; i < 58; i++) bitx(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pr("t5_lk2", K_LK2, 1); pr("t5_err2_init", K_ERR2, 0);
    for (int k = 0; k < 20; k++) begin
      bitx(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      if (k == 13) begin pr("t5_err2_14", K_ERR2, 14); pr("t5_sat2_14", K_SAT2, 0); end
      if (k == 14) begin pr("t5_err2_15", K_ERR2, 15); pr("t5_sat2_15", K_SAT2, 1); end
      if (k == 19) begin
        pr("t5_err2_20", K_ERR2, 15); pr("t5_sat2_20", K_SAT2, 1); pr("t5_lk2_20", K_LK2, 1);
      end
    end
    pr("t5_err1_pre", K_ERR, 8);
    bitx(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    pr("t5_rs_err2", K_ERR2, 0); pr("t5_rs_lk2", K_LK2, 0); pr("t5_rs_bo2", K_BO2, 1);
    pr("t5_rs_bv2", K_BV2, 1);   pr("t5_rs_sat2", K_SAT2, 0);
    pr("t5_rs_err", K_ERR, 0);   pr("t5_rs_lk", K_LK, 0);

    bitx(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pr("drain_queue", K_DRAIN, 0);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
